// File: rtl/ififo_ctrl_pkg.sv
// ififo_ctrl_pkg: shared types and helpers for the input-FIFO sequencer.
//   state_e : sequencer states
//   len_w() : width of a vector count able to hold 0..depth (and flag > depth)
package ififo_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAST_WR,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam int DEPTH_DEF = 64;
  localparam int LEN_W     = $clog2(DEPTH_DEF) + 1;

  function automatic int len_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ififo_ctrl_if.sv
// ififo_ctrl_if: control bundle between the core controller, the sequencer,
// the activation SRAM and the input FIFO.
//   master : core-controller / environment side (drives start, base_addr,
//            len, hold, fifo_full; observes everything else)
//   slave  : the sequencer itself
interface ififo_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 7
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              hold;
  logic              fifo_full;
  logic              sram_cen;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, base_addr, len, hold, fifo_full,
    input  sram_cen, sram_wen, sram_addr, fifo_wr, fifo_rd, busy, done, err
  );

  modport slave (
    input  start, base_addr, len, hold, fifo_full,
    output sram_cen, sram_wen, sram_addr, fifo_wr, fifo_rd, busy, done, err
  );
endinterface

// File: rtl/ififo_ctrl.sv
// ififo_ctrl: activation input-FIFO sequencer.
// On an accepted start it reads len vectors from the activation SRAM into the
// input FIFO, pulses len FIFO reads toward the array (stallable by hold),
// waits col cycles for the column read stagger to empty, then pulses done.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : ififo_ctrl_if.slave (start/base_addr/len/hold/fifo_full in;
//                sram_cen/sram_wen/sram_addr/fifo_wr/fifo_rd/busy/done/err out)
module ififo_ctrl
  import ififo_ctrl_pkg::*;
#(
  parameter int col    = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 11
) (
  input  logic          clk,
  input  logic          reset,
  ififo_ctrl_if.slave   bus
);

  localparam int LW   = len_w(DEPTH);
  localparam int FC_W = $clog2(col) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     ic_q, ic_d;
  logic [LW-1:0]     dc_q, dc_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic              fifo_wr_q, fifo_wr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      ic_q      <= '0;
      dc_q      <= '0;
      fc_q      <= '0;
      fifo_wr_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      ic_q      <= ic_d;
      dc_q      <= dc_d;
      fc_q      <= fc_d;
      fifo_wr_q <= fifo_wr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    ic_d    = ic_q;
    dc_d    = dc_q;
    fc_d    = fc_q;
    err_d   = err_q;
    // SRAM Q arrives one cycle after the read issue, so the FIFO write
    // strobe is simply the LOAD state delayed by one cycle.
    fifo_wr_d = (state_q == S_LOAD);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d = bus.base_addr;
          len_d  = bus.len;
          err_d  = 1'b0;
          ic_d   = '0;
          dc_d   = '0;
          fc_d   = '0;
          if (bus.len == '0) begin
            state_d = S_DONE;
          end else if (bus.len > LW'(DEPTH)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        ic_d = ic_q + LW'(1);
        if (ic_q == len_q - LW'(1)) state_d = S_LAST_WR;
      end
      S_LAST_WR: state_d = S_DRAIN;
      S_DRAIN: begin
        if (!bus.hold) begin
          dc_d = dc_q + LW'(1);
          if (dc_q == len_q - LW'(1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        fc_d = fc_q + FC_W'(1);
        if (fc_q == FC_W'(col - 1)) begin
          fc_d    = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Overflow is recorded but does not stop the write or the sequence.
    if (fifo_wr_q && bus.fifo_full) err_d = 1'b1;
  end

  // done is registered. On the normal path it rises on entry to DONE. On the
  // zero/illegal-len path DONE is entered straight from IDLE with done_q
  // still low, so the pulse lands one cycle later, after busy has dropped.
  assign done_d = ((state_q == S_FLUSH) && (state_d == S_DONE)) ||
                  ((state_q == S_DONE) && !done_q);

  assign bus.sram_cen  = (state_q != S_LOAD);
  assign bus.sram_wen  = 1'b1;
  assign bus.sram_addr = (state_q == S_LOAD) ? base_q + ADDR_W'(ic_q) : '0;
  assign bus.fifo_wr   = fifo_wr_q;
  assign bus.fifo_rd   = (state_q == S_DRAIN) && !bus.hold;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ififo_ctrl.sv
// tb_ififo_ctrl: randomized self-checking bench for ififo_ctrl. Expected
// outputs come from the cycle-level timing rules (load window, write window,
// read count, flush length) evaluated per transaction.
module tb_ififo_ctrl;
  localparam int COL   = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 11;
  localparam int LW    = 7;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   err_m = 1'b0;

  always #5 clk = ~clk;

  ififo_ctrl_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

  ififo_ctrl #(.col(COL), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cen"},  bus.sram_cen, 1);
    chk({tag, "_wen"},  bus.sram_wen, 1);
    chk({tag, "_addr"}, bus.sram_addr, 0);
    chk({tag, "_wr"},   bus.fifo_wr, 0);
    chk({tag, "_rd"},   bus.fifo_rd, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"},  bus.err, 0);
  endtask

  // One transaction: start at cycle 0, check every cycle until the cycle
  // after done. hk0/hn force hold for hn cycles from cycle hk0; xstart pulses
  // stray starts (with junk len/base) during the load window.
  task automatic run(input logic [AW-1:0] b, input int l, input int hold_pct,
                     input int full_pct, input int hk0, input int hn, input bit xstart);
    int L, reads, dcyc, k, nrd, nwr;
    bit legal, h, f, e_wr, e_rd, e_cen, e_busy, e_done;
    logic [AW-1:0] ea;
    legal = (l >= 1 && l <= DEPTH);
    L     = legal ? l : 0;
    dcyc  = legal ? -1 : 2;
    reads = 0; nrd = 0; nwr = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = b; bus.len = LW'(l);
    bus.hold = 1'($urandom_range(1)); bus.fifo_full = 1'b0;
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("idle_err", bus.err, err_m);
    err_m = (l > DEPTH);
    k = 1;
    while (k < 600) begin
      @(negedge clk);
      bus.start     = (xstart && k <= L) ? 1'($urandom_range(1)) : 1'b0;
      bus.base_addr = AW'($urandom);
      bus.len       = LW'($urandom);
      h = (hk0 != 0 && k >= hk0 && k < hk0 + hn) || ($urandom_range(99) < hold_pct);
      f = ($urandom_range(99) < full_pct);
      bus.hold = h; bus.fifo_full = f;
      #1;
      e_cen = !(legal && k <= L);
      ea    = (legal && k <= L) ? b + AW'(k - 1) : '0;
      e_wr  = legal && k >= 2 && k <= L + 1;
      e_rd  = 1'b0;
      if (legal && k >= L + 2 && reads < L) begin
        e_rd = !h;
        if (!h) begin
          reads++;
          if (reads == L) dcyc = k + 1 + COL;
        end
      end
      e_done = (k == dcyc);
      e_busy = legal ? (dcyc < 0 || k <= dcyc) : (k == 1);
      chk("cen", bus.sram_cen, e_cen);
      chk("wen", bus.sram_wen, 1);
      chk("addr", bus.sram_addr, ea);
      chk("wr", bus.fifo_wr, e_wr);
      chk("rd", bus.fifo_rd, e_rd);
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
      chk("err", bus.err, err_m);
      if (e_wr && f) err_m = 1'b1;
      nrd += int'(bus.fifo_rd);
      nwr += int'(bus.fifo_wr);
      if (dcyc > 0 && k == dcyc + 1) break;
      k++;
    end
    bus.start = 1'b0; bus.hold = 1'b0; bus.fifo_full = 1'b0;
    chk("txn_in_bound", k < 600, 1);
    chk("rd_count", nrd, L);
    chk("wr_count", nwr, L);
  endtask

  // Reset arrives in DRAIN after two of five reads.
  task automatic reset_mid_drain();
    int nrd;
    nrd = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 11'h123; bus.len = LW'(5);
    bus.hold = 1'b0; bus.fifo_full = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      nrd += int'(bus.fifo_rd);
    end
    chk("pre_reset_rd", nrd, 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_vals("midrst");
    reset = 1'b0;
    err_m = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0;
    bus.hold = 1'b0; bus.fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;

    run(11'h010, 4, 0, 0, 0, 0, 1'b0);        // basic
    run(11'h200, 3, 0, 0, 6, 2, 1'b0);        // hold two cycles after first rd
    run(11'h055, 0, 0, 0, 0, 0, 1'b0);        // len 0
    run(11'h066, 65, 0, 0, 0, 0, 1'b0);       // illegal len, err
    run(11'h077, 0, 0, 0, 0, 0, 1'b0);        // accepted start clears err
    run(11'h100, 64, 0, 0, 0, 0, 1'b0);       // max len
    run(11'h7FE, 4, 0, 0, 0, 0, 1'b0);        // address wrap
    run(11'h300, 6, 0, 0, 0, 0, 1'b1);        // stray starts during LOAD
    run(11'h400, 5, 0, 30, 0, 0, 1'b0);       // fifo_full during writes
    run(11'h410, 2, 0, 100, 0, 0, 1'b0);      // fifo_full on every write
    reset_mid_drain();
    run(11'h020, 5, 0, 0, 0, 0, 1'b0);        // clean run after reset
    for (int i = 0; i < 25; i++)
      run(AW'($urandom), $urandom_range(0, 70), 30, 5, 0, 0, 1'($urandom_range(1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
